// File: rtl/video_timing_sequencer.sv
// video_timing_sequencer
//   Sequencer/configurator for the horizontal sync counter of the VGA path.
//   Generates PixelClock, drives the horizontal timing words for the current
//   mode, counts lines from LineEnd, and produces vsync, yposition, VideoOn
//   and FrameEnd. Mode changes in RUN take effect only at frame boundaries
//   via a ModeRequest/ModeAck handshake.
//
//   Optional feature macro: VTS_FRAME_COUNT_EN adds output FrameCount[7:0].
//
// Ports:
//   CLK, RESET            clock, synchronous active-high reset
//   Enable                1 = run video timing, 0 = stop
//   ModeSelect/Request    requested mode and its single-cycle strobe
//   ModeAck, CurrentMode  apply acknowledge pulse, mode in effect
//   PixelClock            pixel-rate square wave (ClockDivide CLK per pixel)
//   SynchPulse..FrontPorch horizontal timing words for CurrentMode
//   LineEnd, xposition    inputs from the horizontal counter
//   vsync (active low), yposition, VideoOn, FrameEnd  vertical outputs
//   FrameCount            frame counter (only with VTS_FRAME_COUNT_EN)

module video_timing_sequencer #(
  parameter int xresolution = 10,
  parameter int yresolution = 10,
  parameter int ClockDivide = 4
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   Enable,
  input  logic [1:0]             ModeSelect,
  input  logic                   ModeRequest,
  output logic                   ModeAck,
  output logic [1:0]             CurrentMode,
  output logic                   PixelClock,
  output logic [xresolution-1:0] SynchPulse,
  output logic [xresolution-1:0] BackPorch,
  output logic [xresolution-1:0] ActiveVideo,
  output logic [xresolution-1:0] FrontPorch,
  input  logic                   LineEnd,
  input  logic [xresolution-1:0] xposition,
  output logic                   vsync,
  output logic [yresolution-1:0] yposition,
  output logic                   VideoOn,
  output logic                   FrameEnd
`ifdef VTS_FRAME_COUNT_EN
  ,
  output logic [7:0]             FrameCount
`endif
);

  localparam int CW = (ClockDivide > 2) ? $clog2(ClockDivide) : 1;

  typedef enum logic [1:0] {
    ST_STOP   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SWITCH = 2'd2
  } state_t;

  state_t                 state;
  logic [1:0]             pending;
  logic [CW-1:0]          div_cnt;
  logic                   le_prev;
  logic                   line_adv;

  logic [yresolution-1:0] v_active;
  logic [yresolution-1:0] v_front;
  logic [yresolution-1:0] v_sync;
  logic [yresolution-1:0] v_back;
  logic [yresolution-1:0] v_sync_start;
  logic [yresolution-1:0] v_sync_end;
  logic [yresolution-1:0] v_end;
  logic [yresolution-1:0] y_next;
  logic                   wrap;
  logic                   vsync_next;
  logic                   video_on_next;

  // Mode table; codes 2 and 3 decode as mode 0.
  always_comb begin
    SynchPulse  = xresolution'(96);
    BackPorch   = xresolution'(48);
    ActiveVideo = xresolution'(640);
    FrontPorch  = xresolution'(16);
    v_active    = yresolution'(480);
    v_front     = yresolution'(10);
    v_sync      = yresolution'(2);
    v_back      = yresolution'(33);
    if (CurrentMode == 2'd1) begin
      SynchPulse  = xresolution'(4);
      BackPorch   = xresolution'(2);
      ActiveVideo = xresolution'(16);
      FrontPorch  = xresolution'(2);
      v_active    = yresolution'(8);
      v_front     = yresolution'(1);
      v_sync      = yresolution'(2);
      v_back      = yresolution'(1);
    end
  end

  always_comb begin
    v_sync_start = v_active + v_front;
    v_sync_end   = v_sync_start + v_sync;
    v_end        = v_sync_end + v_back;
  end

  // Next line number; vsync/VideoOn are derived from it so that they are
  // registered in step with yposition.
  always_comb begin
    y_next = yposition;
    wrap   = 1'b0;
    if (line_adv) begin
      if (yposition == v_end - yresolution'(1)) begin
        y_next = '0;
        wrap   = 1'b1;
      end else begin
        y_next = yposition + yresolution'(1);
      end
    end
    vsync_next    = !((y_next >= v_sync_start) && (y_next < v_sync_end));
    video_on_next = (xposition < ActiveVideo) && (y_next < v_active);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= ST_STOP;
      CurrentMode <= '0;
      pending     <= '0;
      div_cnt     <= '0;
      PixelClock  <= 1'b0;
      vsync       <= 1'b1;
      yposition   <= '0;
      VideoOn     <= 1'b0;
      FrameEnd    <= 1'b0;
      ModeAck     <= 1'b0;
      le_prev     <= 1'b0;
      line_adv    <= 1'b0;
`ifdef VTS_FRAME_COUNT_EN
      FrameCount  <= '0;
`endif
    end else begin
      le_prev  <= LineEnd;
      line_adv <= LineEnd & ~le_prev;
      ModeAck  <= 1'b0;
      FrameEnd <= 1'b0;

      case (state)
        ST_STOP: begin
          div_cnt    <= '0;
          PixelClock <= 1'b0;
          yposition  <= '0;
          vsync      <= 1'b1;
          VideoOn    <= 1'b0;
          if (ModeRequest) begin
            CurrentMode <= ModeSelect;
            ModeAck     <= 1'b1;
          end
          if (Enable) begin
            state <= ST_RUN;
          end
        end

        ST_RUN, ST_SWITCH: begin
          if (!Enable) begin
            // STOP entry: a pending (or coincident) request is applied here.
            state      <= ST_STOP;
            div_cnt    <= '0;
            PixelClock <= 1'b0;
            yposition  <= '0;
            vsync      <= 1'b1;
            VideoOn    <= 1'b0;
`ifdef VTS_FRAME_COUNT_EN
            FrameCount <= '0;
`endif
            if (state == ST_SWITCH) begin
              CurrentMode <= ModeRequest ? ModeSelect : pending;
              ModeAck     <= 1'b1;
            end else if (ModeRequest) begin
              CurrentMode <= ModeSelect;
              ModeAck     <= 1'b1;
            end
          end else begin
            div_cnt    <= (div_cnt == CW'(ClockDivide - 1)) ? '0 : div_cnt + CW'(1);
            PixelClock <= (div_cnt < CW'(ClockDivide / 2));
            yposition  <= y_next;
            vsync      <= vsync_next;
            VideoOn    <= video_on_next;
            FrameEnd   <= wrap;
`ifdef VTS_FRAME_COUNT_EN
            if (wrap) begin
              FrameCount <= FrameCount + 8'd1;
            end
`endif
            if (state == ST_RUN) begin
              // A request coinciding with FrameEnd waits for the next one,
              // since apply is only checked once already in SWITCH.
              if (ModeRequest) begin
                pending <= ModeSelect;
                state   <= ST_SWITCH;
              end
            end else begin
              if (FrameEnd) begin
                CurrentMode <= ModeRequest ? ModeSelect : pending;
                ModeAck     <= 1'b1;
                state       <= ST_RUN;
              end else if (ModeRequest) begin
                pending <= ModeSelect;
              end
            end
          end
        end

        default: begin
          state <= ST_STOP;
        end
      endcase
    end
  end

endmodule

// File: doc/video_timing_sequencer.md
# video_timing_sequencer

Sequencer and configurator for the horizontal sync counter in the VGA video path.
- Generates the PixelClock square wave that the horizontal counter samples.
- Drives the horizontal timing words (SynchPulse, BackPorch, ActiveVideo, FrontPorch) from a selectable mode table.
- Counts lines from the horizontal LineEnd signal and produces vsync, yposition, VideoOn and frame boundaries.
- Applies mode changes only at frame boundaries, using a request/acknowledge handshake.

## Interface
Parameters:
- xresolution, 10, width of horizontal timing words and xposition.
- yresolution, 10, width of vertical counter and vertical timing constants.
- ClockDivide, 4, CLK cycles per pixel; legal range is even values ≥ 2.

Ports:
- CLK  in  1  system clock; the only clock.
- RESET  in  1  synchronous, active-high reset.
- Enable  in  1  1 = run video timing; 0 = stop.
- ModeSelect  in  2  requested mode, sampled when ModeRequest = 1.
- ModeRequest  in  1  single-cycle request to change mode.
- ModeAck  out  1  single-cycle pulse when the new mode is applied.
- CurrentMode  out  2  mode currently applied.
- PixelClock  out  1  pixel-rate square wave.
- SynchPulse, BackPorch, ActiveVideo, FrontPorch  out  xresolution each  horizontal timing words for the current mode.
- LineEnd  in  1  end-of-line level from the horizontal counter.
- xposition  in  xresolution  current horizontal pixel position.
- vsync  out  1  vertical sync, active low.
- yposition  out  yresolution  current line number.
- VideoOn  out  1  registered active-video flag.
- FrameEnd  out  1  single-cycle pulse at frame wrap.

## Operation
Mode table (horizontal active/front/sync/back; vertical active/front/sync/back):
- Mode 0: H 640/16/96/48; V 480/10/2/33.
- Mode 1 (simulation mode): H 16/2/4/2; V 8/1/2/1.
- Modes 2 and 3: decode identically to mode 0, but CurrentMode reports the requested code.

PixelClock divider:
- Counter runs 0..ClockDivide-1.
- PixelClock = 1 while count < ClockDivide/2.
- In STOP the counter is held at 0 and PixelClock = 0.

Line advance:
- Occurs on a LineEnd rising edge, detected with a registered previous value of LineEnd.
- VEnd = Vactive + Vfront + Vsync + Vback. Width is yresolution with no truncation; mode 0 VEnd = 525.
- yposition counts 0..VEnd-1. On an advance at VEnd-1 it wraps to 0 and FrameEnd pulses in the same cycle that yposition goes to 0.

Vertical outputs (all registered, updated every CLK):
- vsync = 0 iff Vactive+Vfront ≤ yposition < Vactive+Vfront+Vsync.
- VideoOn = (xposition < ActiveVideo) && (yposition < Vactive).

State machine:
- STOP:
  - yposition = 0, vsync = 1, VideoOn = 0.
  - A ModeRequest applies immediately: CurrentMode updates and ModeAck pulses on the following cycle.
  - Enable = 1 → RUN.
- RUN:
  - ModeRequest → latch ModeSelect into pending, go to SWITCH.
  - Enable = 0 → STOP.
- SWITCH:
  - Counting continues.
  - A further ModeRequest overwrites pending (latest wins); only one ModeAck is issued.
  - On FrameEnd: CurrentMode ← pending, ModeAck pulses the next cycle, go to RUN.
  - Enable = 0 → STOP; pending is applied and acknowledged on STOP entry.
- ModeRequest in the same cycle as FrameEnd while in RUN: the request is latched and waits for the next frame end. It is never applied mid-frame.

## Timing
- RESET (synchronous, priority over all inputs):
  - State STOP, CurrentMode 0, pending 0, divider 0.
  - PixelClock 0, vsync 1, yposition 0, VideoOn 0, FrameEnd 0, ModeAck 0.
  - Timing words show mode 0 values.
- Enable rising in STOP: RUN is entered on the next edge. The first PixelClock high begins the cycle after that.
- Timing words are combinational from CurrentMode. They change in the same cycle CurrentMode changes, i.e. the cycle ModeAck is asserted.
- yposition, vsync and FrameEnd lag the LineEnd rising edge by 2 CLK: 1 cycle for edge detect, 1 for the register.
- RESET asserted mid-frame: all state returns to reset values on that edge; a pending request is discarded with no ModeAck.

## Configuration
- VTS_FRAME_COUNT_EN defined: adds output FrameCount [7:0].
  - Increments on each FrameEnd and wraps 255→0.
  - Cleared by RESET and on STOP entry.
- VTS_FRAME_COUNT_EN undefined: the FrameCount port and its logic are absent; all other behaviour is identical.

## Test plan
- Reset then Enable=1, mode 0, ClockDivide=4 → PixelClock period 4 CLK, high 2 CLK; vsync=1; yposition=0.
- Mode 1 with a LineEnd pulse every 40 CLK → yposition cycles 0..11. vsync=0 only at yposition 9,10. FrameEnd pulses once per 12 lines, as yposition goes 11→0.
- In RUN, ModeRequest with ModeSelect=1 at yposition 3 (mode 0) → no change until the frame wrap. CurrentMode=1 and ActiveVideo=16 with a single ModeAck the cycle after FrameEnd.
- In SWITCH, requests for mode 2 then mode 1 → exactly one ModeAck, CurrentMode=1.
- Enable=0 at yposition 100 with a request pending → next cycle: STOP, yposition=0, vsync=1, PixelClock=0; ModeAck pulses once.
- RESET at yposition 200 with a request pending → next cycle all reset values, CurrentMode=0, no ModeAck; with VTS_FRAME_COUNT_EN, FrameCount=0.
